// File: rtl/cdb_arbiter.sv
// Purpose : per-FU result FIFOs arbitrated round-robin onto one registered common data bus.
// Latency : FU result to cdb_valid is 2 cycles on an idle bus, or 1 cycle with CDB_BYPASS_EN.
// Backpr. : cdb_* hold while cdb_valid & ~cdb_ready; fu_full[i] makes FU i hold its result.
//
// Ports:
//   clk, rstn (sync, active-low), flush   - clock, reset, mispredict squash
//   fu_valid/fu_data/fu_dr/fu_full        - per-FU result inputs and backpressure
//   cdb_valid/cdb_ready/cdb_data/cdb_dr/cdb_fu_id - registered broadcast bus
//   err_overflow                          - sticky: result arrived while its FIFO was full
// Optional feature macro: CDB_BYPASS_EN (empty-FIFO results go straight onto the bus).
module cdb_arbiter #(
  parameter  int NUM_FU     = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int DATA_W     = 32,
  parameter  int TAG_W      = 6,
  localparam int FU_ID_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  input  logic [NUM_FU*TAG_W-1:0]  fu_dr,
  output logic [NUM_FU-1:0]        fu_full,
  input  logic                     cdb_ready,
  output logic                     cdb_valid,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [TAG_W-1:0]         cdb_dr,
  output logic [FU_ID_W-1:0]       cdb_fu_id,
  output logic                     err_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit distinguishes full from empty

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  dr;
  } entry_t;

  entry_t             mem_q    [NUM_FU][FIFO_DEPTH];
  entry_t             mem_d    [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q [NUM_FU];
  logic [PW-1:0]      wr_ptr_d [NUM_FU];
  logic [PW-1:0]      rd_ptr_q [NUM_FU];
  logic [PW-1:0]      rd_ptr_d [NUM_FU];
  logic [FU_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]   cdb_dr_q, cdb_dr_d;
  logic [FU_ID_W-1:0] cdb_fu_id_q, cdb_fu_id_d;
  logic               err_overflow_q, err_overflow_d;

  logic [NUM_FU-1:0]  empty, full, req;
  logic               load, gnt_vld, bypass, pop;
  logic [FU_ID_W-1:0] gnt_idx;
  entry_t             head;

  function automatic logic [FU_ID_W-1:0] wrap_idx(input logic [FU_ID_W-1:0] base, input int k);
    return FU_ID_W'((int'(base) + k) % NUM_FU);
  endfunction

  // Status is decoded from registered pointers only, so fu_full never depends on this cycle's inputs.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = ((wr_ptr_q[i] - rd_ptr_q[i]) == PW'(FIFO_DEPTH));
    end
  end

  always_comb begin
`ifdef CDB_BYPASS_EN
    // A valid result at an empty FIFO may compete; a non-empty FIFO always offers its head first.
    req = ~empty | fu_valid;
`else
    req = ~empty;
`endif
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!gnt_vld && req[wrap_idx(rr_ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rr_ptr_d       = rr_ptr_q;
    cdb_valid_d    = cdb_valid_q;
    cdb_data_d     = cdb_data_q;
    cdb_dr_d       = cdb_dr_q;
    cdb_fu_id_d    = cdb_fu_id_q;
    err_overflow_d = err_overflow_q | (|(fu_valid & full));

    load = ~cdb_valid_q | cdb_ready;
    head = mem_q[gnt_idx][rd_ptr_q[gnt_idx][AW-1:0]];
`ifdef CDB_BYPASS_EN
    bypass = load & gnt_vld & empty[gnt_idx];
`else
    bypass = 1'b0;
`endif
    pop = load & gnt_vld & ~bypass;

    if (load) begin
      cdb_valid_d = gnt_vld;
      if (gnt_vld) begin
        if (bypass) begin
          cdb_data_d = fu_data[gnt_idx*DATA_W +: DATA_W];
          cdb_dr_d   = fu_dr[gnt_idx*TAG_W +: TAG_W];
        end else begin
          cdb_data_d = head.data;
          cdb_dr_d   = head.dr;
        end
        cdb_fu_id_d = gnt_idx;
        rr_ptr_d    = wrap_idx(gnt_idx, 1);
      end
    end

    for (int i = 0; i < NUM_FU; i++) begin
      // A bypassed result is already on the bus and must not also be buffered.
      if (fu_valid[i] && !full[i] && !(bypass && gnt_idx == FU_ID_W'(i))) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = '{data: fu_data[i*DATA_W +: DATA_W],
                                          dr:   fu_dr[i*TAG_W +: TAG_W]};
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end
      if (pop && gnt_idx == FU_ID_W'(i)) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
    end

    // Squash wins over enqueue and grant; the bus payload keeps its last value.
    if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end
      rr_ptr_d    = '0;
      cdb_valid_d = 1'b0;
      cdb_data_d  = cdb_data_q;
      cdb_dr_d    = cdb_dr_q;
      cdb_fu_id_d = cdb_fu_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_data_q     <= '0;
      cdb_dr_q       <= '0;
      cdb_fu_id_q    <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_data_q     <= cdb_data_d;
      cdb_dr_q       <= cdb_dr_d;
      cdb_fu_id_q    <= cdb_fu_id_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through reset pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fu_full      = full;
  assign cdb_valid    = cdb_valid_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_dr       = cdb_dr_q;
  assign cdb_fu_id    = cdb_fu_id_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose : directed bench for cdb_arbiter (NUM_FU=4, FIFO_DEPTH=4, DATA_W=32, TAG_W=6).
// Latency : inputs driven on negedge, outputs sampled on the following negedge.
// Backpr. : cdb_ready driven per scenario; FU model honours fu_full except where overflow is forced.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [127:0] fu_data;
  logic [23:0]  fu_dr;
  logic [3:0]   fu_full;
  logic         cdb_ready;
  logic         cdb_valid;
  logic [31:0]  cdb_data;
  logic [5:0]   cdb_dr;
  logic [1:0]   cdb_fu_id;
  logic         err_overflow;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .fu_valid     (fu_valid),
    .fu_data      (fu_data),
    .fu_dr        (fu_dr),
    .fu_full      (fu_full),
    .cdb_ready    (cdb_ready),
    .cdb_valid    (cdb_valid),
    .cdb_data     (cdb_data),
    .cdb_dr       (cdb_dr),
    .cdb_fu_id    (cdb_fu_id),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic set_fu(input int i, input logic [31:0] d, input logic [5:0] t);
    fu_data[i*32 +: 32] = d;
    fu_dr[i*6 +: 6]     = t;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; cdb_ready = 1'b1;
    fu_valid = 4'hF; fu_data = '1; fu_dr = '1;
    repeat (2) @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
    checks++; if (cdb_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", cdb_data); end
    checks++; if (cdb_dr !== 6'h0) begin failures++; $display("FAIL reset_dr got=%h exp=0", cdb_dr); end
    checks++; if (cdb_fu_id !== 2'h0) begin failures++; $display("FAIL reset_fu_id got=%h exp=0", cdb_fu_id); end
    checks++; if (fu_full !== 4'h0) begin failures++; $display("FAIL reset_fu_full got=%b exp=0000", fu_full); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overflow); end
    rstn = 1'b1; fu_valid = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_nothing_buffered got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_single();
    fu_valid = 4'b0001; set_fu(0, 32'h0000_00AB, 6'd5);
    @(negedge clk);
    fu_valid = 4'h0;
`ifndef CDB_BYPASS_EN
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", cdb_valid); end
    @(negedge clk);
`endif
    checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", cdb_valid); end
    checks++; if (cdb_data !== 32'hAB) begin failures++; $display("FAIL single_data got=%h exp=ab", cdb_data); end
    checks++; if (cdb_dr !== 6'd5) begin failures++; $display("FAIL single_dr got=%0d exp=5", cdb_dr); end
    checks++; if (cdb_fu_id !== 2'd0) begin failures++; $display("FAIL single_fu_id got=%0d exp=0", cdb_fu_id); end
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    do_flush();
    fu_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_fu(i, 32'hA0 + i, 6'(10 + i));
    @(negedge clk);
    fu_valid = 4'h0;
`ifndef CDB_BYPASS_EN
    @(negedge clk);
`endif
    for (int i = 0; i < 4; i++) begin
      checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, cdb_valid); end
      checks++; if (cdb_fu_id !== 2'(i)) begin failures++; $display("FAIL rr_fu_id[%0d] got=%0d exp=%0d", i, cdb_fu_id, i); end
      checks++; if (cdb_data !== 32'hA0 + i) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, cdb_data, 32'hA0 + i); end
      @(negedge clk);
    end
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_backpressure();
    do_flush();
    cdb_ready = 1'b0;
    // First result lands in the output register, the next four fill FIFO1.
    for (int k = 0; k < 5; k++) begin
      fu_valid = 4'b0010; set_fu(1, 32'h100 + k, 6'(k));
      @(negedge clk);
      checks++; if (fu_full[1] !== (k == 4)) begin failures++; $display("FAIL bp_full[%0d] got=%b exp=%b", k, fu_full[1], (k == 4)); end
    end
    fu_valid = 4'h0;  // FU now holds its next result
    repeat (2) @(negedge clk);
    checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", cdb_valid); end
    checks++; if (cdb_data !== 32'h100) begin failures++; $display("FAIL bp_hold_data got=%h exp=100", cdb_data); end
    checks++; if (cdb_fu_id !== 2'd1) begin failures++; $display("FAIL bp_hold_id got=%0d exp=1", cdb_fu_id); end
    checks++; if (fu_full !== 4'b0010) begin failures++; $display("FAIL bp_still_full got=%b exp=0010", fu_full); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL bp_no_err got=%b exp=0", err_overflow); end
    fu_valid = 4'b0010; set_fu(1, 32'hDEAD, 6'd63);
    @(negedge clk);
    fu_valid = 4'h0;
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", err_overflow); end
    checks++; if (cdb_data !== 32'h100) begin failures++; $display("FAIL bp_hold_after_force got=%h exp=100", cdb_data); end
    cdb_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      checks++; if (cdb_data !== 32'h100 + k) begin failures++; $display("FAIL bp_drain_data[%0d] got=%h exp=%h", k, cdb_data, 32'h100 + k); end
      checks++; if (cdb_dr !== 6'(k)) begin failures++; $display("FAIL bp_drain_dr[%0d] got=%0d exp=%0d", k, cdb_dr, k); end
    end
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_flush();
    cdb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fu_valid = 4'b0001; set_fu(0, 32'h200 + k, 6'(k));
      @(negedge clk);
    end
    fu_valid = 4'h0;
    checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%b exp=1", cdb_valid); end
    checks++; if (cdb_data !== 32'h200) begin failures++; $display("FAIL flush_pre_data got=%h exp=200", cdb_data); end
    flush = 1'b1; fu_valid = 4'b0100; set_fu(2, 32'h222, 6'd22);
    @(negedge clk);
    flush = 1'b0; fu_valid = 4'h0; cdb_ready = 1'b1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", cdb_valid); end
    checks++; if (fu_full !== 4'h0) begin failures++; $display("FAIL flush_full got=%b exp=0000", fu_full); end
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL flush_err_kept got=%b exp=1", err_overflow); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_discard[%0d] got=%b data=%h exp_valid=0", c, cdb_valid, cdb_data); end
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rx   = 0;
    for (int cyc = 0; cyc < 200 && rx < 12; cyc++) begin
      cdb_ready = (cyc % 2 == 0);
      if (cdb_valid && cdb_ready) begin
        checks++; if (cdb_data !== 32'h300 + rx) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", rx, cdb_data, 32'h300 + rx); end
        checks++; if (cdb_fu_id !== 2'd3) begin failures++; $display("FAIL wrap_fu_id[%0d] got=%0d exp=3", rx, cdb_fu_id); end
        rx++;
      end
      if (sent < 12 && !fu_full[3]) begin
        fu_valid = 4'b1000; set_fu(3, 32'h300 + sent, 6'(sent));
        sent++;
      end else begin
        fu_valid = 4'h0;
      end
      @(negedge clk);
    end
    fu_valid = 4'h0;
    checks++; if (rx !== 12) begin failures++; $display("FAIL wrap_count got=%0d exp=12", rx); end
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b exp=0", cdb_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
